note_judge: RTL



---
 rtl/note_judge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/note_judge.sv
// Note judge: walks the chart ROM, keeps song time in game ticks, and pulses hit/miss per note.
// Optional build macro STRAY_MISS_EN: a press outside the window of the current note gives a miss.
module note_judge #(
    parameter int TICK_DIV  = 500000,
    parameter int NUM_NOTES = 32,
    parameter int ADDR_W    = 5,
    parameter int TIME_W    = 12,
    parameter int WIN       = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              hit_key,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [TIME_W-1:0] note_time,
    output logic [TIME_W-1:0] song_time,
    output logic              hit,
    output logic              miss,
    output logic              done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] T_END    = '1;
    localparam logic [TIME_W-1:0] T_SAT    = {{(TIME_W-1){1'b1}}, 1'b0};
    localparam logic [ADDR_W:0]   ADDR_END = (ADDR_W+1)'(NUM_NOTES);
    localparam logic [TIME_W:0]   WIN_X    = (TIME_W+1)'(WIN);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, TRACK, FINISH} state_t;

    state_t            state, state_nx;
    // One extra bit so a full chart of NUM_NOTES entries is distinguishable from address 0.
    logic [ADDR_W:0]   addr_q;
    logic [PRE_W-1:0]  presc;
    logic [TIME_W-1:0] cur_note;
    logic              hit_key_q;
    logic              running, tick, press, in_win, closing;
    logic              hit_d, miss_d, adv;
    logic [TIME_W:0]   st_x, cn_x;

    assign running = (state == FETCH) || (state == WAIT_DATA) || (state == TRACK);
    assign tick    = running && (presc == PRE_LAST);
    assign press   = hit_key & ~hit_key_q;

    assign st_x    = {1'b0, song_time};
    assign cn_x    = {1'b0, cur_note};
    assign in_win  = (st_x + WIN_X >= cn_x) && (st_x <= cn_x + WIN_X);
    // >= rather than == so a note already past its window still gets closed on the next tick.
    assign closing = tick && (st_x >= cn_x + WIN_X);

    assign note_addr = addr_q[ADDR_W-1:0];
    assign done      = (state == FINISH);

    always_comb begin
        state_nx = state;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        adv      = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:      state_nx = FETCH;
                FETCH:     state_nx = WAIT_DATA;
                WAIT_DATA: begin
                    if (note_time == T_END || addr_q == ADDR_END)
                        state_nx = FINISH;
                    else
                        state_nx = TRACK;
                end
                TRACK: begin
                    // The closing tick wins over a same-cycle press.
                    if (closing) begin
                        miss_d   = 1'b1;
                        adv      = 1'b1;
                        state_nx = FETCH;
                    end else if (press && in_win) begin
                        hit_d    = 1'b1;
                        adv      = 1'b1;
                        state_nx = FETCH;
                    end
`ifdef STRAY_MISS_EN
                    else if (press) begin
                        miss_d = 1'b1;
                    end
`else
`endif
                end
                FINISH:    state_nx = FINISH;
                default:   state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            presc     <= '0;
            song_time <= '0;
            cur_note  <= '0;
            hit_key_q <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else if (!enable) begin
            addr_q    <= '0;
            presc     <= '0;
            song_time <= '0;
            cur_note  <= '0;
            hit_key_q <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
        end else begin
            hit_key_q <= hit_key;
            hit       <= hit_d;
            miss      <= miss_d;
            if (running)
                presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
            if (tick && song_time != T_SAT)
                song_time <= song_time + TIME_W'(1);
            if (state == WAIT_DATA)
                cur_note <= note_time;
            if (adv)
                addr_q <= addr_q + (ADDR_W+1)'(1);
        end
    end

endmodule
